// File: rtl/pyramid_jump_engine.sv
// pyramid_jump_engine: moves one jumping character between cube centres on a
// pyramid of N_ROWS rows. It tracks a (row, col) cube position, walks the
// sprite one pixel per tick (y leg first, then x leg), detects jumps that
// leave the pyramid and runs the fall / KO / respawn sequence with a lives
// counter.
module pyramid_jump_engine #(
  parameter int N_ROWS    = 7,
  parameter int N_LIVES   = 3,
  parameter int IDXW      = 5,
  parameter int DEF_SPEED = 100000,
  parameter int FALL_PX   = 64,
  parameter int KO_CYCLES = 131072
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            restart,
  input  logic            pause,
  input  logic [31:0]     speed_in,
  input  logic [10:0]     x_top,
  input  logic [9:0]      y_top,
  input  logic [10:0]     dx,
  input  logic [9:0]      dy,
  input  logic            jump_req,
  input  logic [1:0]      jump_dir,
  output logic            jump_ack,
  output logic [20:0]     sprite_xy,
  output logic [3:0]      row,
  output logic [3:0]      col,
  output logic [2:0]      state,
  output logic [2:0]      lives,
  output logic            done_move,
  output logic            land_valid,
  output logic [IDXW-1:0] land_idx,
  output logic            fell,
  output logic            game_over
);

  typedef enum logic [2:0] {
    ST_SPAWN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LEG_Y = 3'd2,
    ST_LEG_X = 3'd3,
    ST_FALL  = 3'd4,
    ST_KO    = 3'd5,
    ST_OVER  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         row_q, row_d, col_q, col_d;
  logic signed [5:0]  tr_q, tr_d, tc_q, tc_d;
  logic               off_q, off_d;
  logic [10:0]        x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic [2:0]         lives_q, lives_d;
  logic [31:0]        cnt_q, cnt_d;   // tick prescaler
  logic [31:0]        aux_q, aux_d;   // fall steps in FALL, clocks in KO
  logic               ack_q, ack_d, done_q, done_d, landv_q, landv_d, fell_q, fell_d;
  logic [IDXW-1:0]    idx_q, idx_d;

  logic [31:0]        spd;
  logic               tick;
  logic signed [11:0] tr12, tc12, tx12, ty12;
  logic [10:0]        tx;
  logic [9:0]         ty;
  logic signed [5:0]  tr_n, tc_n;
  logic               off_n;
  int                 idx_i;

  // Tick generation: one-cycle strobe every spd unpaused clocks.
  always_comb begin
    spd  = (speed_in == 32'd0) ? 32'(DEF_SPEED) : speed_in;
    tick = (cnt_q == spd - 32'd1);
  end

  // Pixel centre of the latched target cube, signed 12-bit then truncated.
  always_comb begin
    tr12 = {{6{tr_q[5]}}, tr_q};
    tc12 = {{6{tc_q[5]}}, tc_q};
    tx12 = $signed({1'b0, x_top}) + tr12 * $signed({1'b0, dx});
    ty12 = $signed({2'b00, y_top}) + ((tc12 <<< 1) - tr12) * $signed({2'b00, dy});
    tx   = tx12[10:0];
    ty   = ty12[9:0];
    idx_i = (int'(tr_q) * (int'(tr_q) + 1)) / 2 + int'(tc_q);
  end

  // Candidate target cube for the requested direction and its legality.
  always_comb begin
    tr_n = $signed({2'b00, row_q}) + (jump_dir[1] ? -6'sd1 : 6'sd1);
    case (jump_dir)
      2'b00:   tc_n = $signed({2'b00, col_q}) + 6'sd1;
      2'b11:   tc_n = $signed({2'b00, col_q}) - 6'sd1;
      default: tc_n = $signed({2'b00, col_q});
    endcase
    off_n = (tr_n < 6'sd0) || (tr_n >= $signed(6'(N_ROWS))) ||
            (tc_n < 6'sd0) || (tc_n > tr_n);
  end

  // Next-state, datapath and pulse logic; restart beats pause beats the rest.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tr_d    = tr_q;
    tc_d    = tc_q;
    off_d   = off_q;
    x_d     = x_q;
    y_d     = y_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    aux_d   = aux_q;
    idx_d   = idx_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    landv_d = 1'b0;
    fell_d  = 1'b0;
    if (restart) begin
      state_d = ST_SPAWN;
      lives_d = 3'(N_LIVES);
      cnt_d   = 32'd0;
      aux_d   = 32'd0;
    end else if (!pause) begin
      case (state_q)
        ST_SPAWN: begin
          x_d     = x_top;
          y_d     = y_top;
          row_d   = 4'd0;
          col_d   = 4'd0;
          state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (jump_req) begin
            tr_d    = tr_n;
            tc_d    = tc_n;
            off_d   = off_n;
            ack_d   = 1'b1;
            state_d = ST_LEG_Y;
          end
        end
        ST_LEG_Y: begin
          if (y_q == ty)
            state_d = ST_LEG_X;
          else if (tick)
            y_d = (y_q < ty) ? y_q + 10'd1 : y_q - 10'd1;
        end
        ST_LEG_X: begin
          if (x_q == tx) begin
            done_d = 1'b1;
            aux_d  = 32'd0;
            if (!off_q) begin
              row_d   = tr_q[3:0];
              col_d   = tc_q[3:0];
              landv_d = 1'b1;
              idx_d   = idx_i[IDXW-1:0];
              state_d = ST_IDLE;
            end else begin
              state_d = ST_FALL;
            end
          end else if (tick) begin
            x_d = (x_q < tx) ? x_q + 11'd1 : x_q - 11'd1;
          end
        end
        ST_FALL: begin
          if (aux_q == 32'(FALL_PX)) begin
            fell_d  = 1'b1;
            aux_d   = 32'd0;
            state_d = ST_KO;
          end else if (tick) begin
            x_d   = x_q + 11'd1;
            aux_d = aux_q + 32'd1;
          end
        end
        ST_KO: begin
          if (aux_q == 32'(KO_CYCLES - 1)) begin
            aux_d   = 32'd0;
            lives_d = lives_q - 3'd1;
            state_d = (lives_q == 3'd1) ? ST_OVER : ST_SPAWN;
          end else begin
            aux_d = aux_q + 32'd1;
          end
        end
        default: ;  // ST_OVER: only restart leaves
      endcase
      cnt_d = (state_d != state_q || tick) ? 32'd0 : cnt_q + 32'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SPAWN;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
      tr_q    <= 6'sd0;
      tc_q    <= 6'sd0;
      off_q   <= 1'b0;
      x_q     <= 11'd0;
      y_q     <= 10'd0;
      lives_q <= 3'(N_LIVES);
      cnt_q   <= 32'd0;
      aux_q   <= 32'd0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      landv_q <= 1'b0;
      fell_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tr_q    <= tr_d;
      tc_q    <= tc_d;
      off_q   <= off_d;
      x_q     <= x_d;
      y_q     <= y_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      aux_q   <= aux_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      landv_q <= landv_d;
      fell_q  <= fell_d;
    end
  end

  // Output mapping.
  always_comb begin
    jump_ack   = ack_q;
    sprite_xy  = {x_q, y_q};
    row        = row_q;
    col        = col_q;
    state      = state_q;
    lives      = lives_q;
    done_move  = done_q;
    land_valid = landv_q;
    land_idx   = idx_q;
    fell       = fell_q;
    game_over  = (state_q == ST_OVER);
  end

endmodule
